io_burst_reader: RTL and testbench

IO_BURST_READER -- requirements
Module: io_burst_reader

---
 rtl/io_burst_reader.sv | 146 ++++++++++++++
 tb/tb_io_burst_reader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_burst_reader.sv
// Burst read engine: splits a word transfer into bounded read bursts toward the
// DMem IO controller and streams the returned words through a FWFT output FIFO.
module io_burst_reader #(
  parameter int AWIDTH        = 32,
  parameter int DWIDTH        = 32,
  parameter int MAX_BURST_LEN = 8,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [31:0]       cmd_len,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [AWIDTH-1:0] req_read_addr,
  output logic [31:0]       req_read_len,
  output logic              req_read_addr_valid,
  input  logic              req_read_addr_ready,
  input  logic [DWIDTH-1:0] resp_read_data,
  input  logic              resp_read_data_valid,
  output logic              resp_read_data_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int          PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] MAXB  = 32'(MAX_BURST_LEN);
  localparam logic [31:0] DEPTH = 32'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] cur_addr, cur_addr_nxt;
  logic [31:0]       remaining, remaining_nxt;
  logic [31:0]       beat_cnt, beat_cnt_nxt;
  logic [31:0]       burst, free_slots;
  logic              done_q, done_nxt;

  logic [DWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop, fifo_full, fifo_empty;

  assign burst      = (remaining < MAXB) ? remaining : MAXB;
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign free_slots = DEPTH - 32'(count);

  assign cmd_ready            = (state == IDLE);
  assign busy                 = (state != IDLE);
  assign done                 = done_q;
  assign req_read_addr        = cur_addr;
  assign req_read_len         = burst;
  // Credit check: only ask for a burst the FIFO can fully absorb.
  assign req_read_addr_valid  = (state == REQ) && (free_slots >= burst);
  assign resp_read_data_ready = (state == RESP) && !fifo_full;
  assign out_valid            = !fifo_empty;
  assign out_data             = mem[rd_ptr];

  assign push = resp_read_data_valid && resp_read_data_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_addr  <= cur_addr_nxt;
      remaining <= remaining_nxt;
      beat_cnt  <= beat_cnt_nxt;
      done_q    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_addr_nxt  = cur_addr;
    remaining_nxt = remaining;
    beat_cnt_nxt  = beat_cnt;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cur_addr_nxt  = cmd_addr;
          remaining_nxt = cmd_len;
          beat_cnt_nxt  = '0;
          if (cmd_len == '0) done_nxt  = 1'b1;
          else               state_nxt = REQ;
        end
      end
      REQ: begin
        if (req_read_addr_valid && req_read_addr_ready) begin
          beat_cnt_nxt = '0;
          state_nxt    = RESP;
        end
      end
      RESP: begin
        if (push) begin
          if (beat_cnt == burst - 32'd1) begin
            remaining_nxt = remaining - burst;
            cur_addr_nxt  = cur_addr + AWIDTH'(burst);
            beat_cnt_nxt  = '0;
            if (remaining == burst) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = REQ;
            end
          end else begin
            beat_cnt_nxt = beat_cnt + 32'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= resp_read_data;
  end

endmodule

// File: tb/tb_io_burst_reader.sv
// Self-checking bench for io_burst_reader: memory responder, consumer and a
// burst-splitting reference model over directed and randomized-stall transfers.
module tb_io_burst_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h0000_1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Instance A: default burst 8, FIFO 16
  logic [31:0] cmd_addr = '0, cmd_len = '0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] req_addr, req_len;
  logic        req_valid, req_ready = 1'b1;
  logic [31:0] resp_data = '0;
  logic        resp_valid = 1'b0, resp_ready;
  logic [31:0] out_data;
  logic        out_valid, out_ready = 1'b0;
  logic        busy, done;

  io_burst_reader #(.AWIDTH(32), .DWIDTH(32), .MAX_BURST_LEN(8), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .req_read_addr(req_addr), .req_read_len(req_len),
    .req_read_addr_valid(req_valid), .req_read_addr_ready(req_ready),
    .resp_read_data(resp_data), .resp_read_data_valid(resp_valid), .resp_read_data_ready(resp_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  // Instance B: burst 4, for address wrap-around
  logic [31:0] b_cmd_addr = '0, b_cmd_len = '0;
  logic        b_cmd_valid = 1'b0, b_cmd_ready;
  logic [31:0] b_req_addr, b_req_len;
  logic        b_req_valid, b_req_ready = 1'b1;
  logic [31:0] b_resp_data = '0;
  logic        b_resp_valid = 1'b0, b_resp_ready;
  logic [31:0] b_out_data;
  logic        b_out_valid, b_out_ready = 1'b1;
  logic        b_busy, b_done;

  io_burst_reader #(.AWIDTH(32), .DWIDTH(32), .MAX_BURST_LEN(4), .FIFO_DEPTH(8)) dut4 (
    .clk(clk), .rst(rst),
    .cmd_addr(b_cmd_addr), .cmd_len(b_cmd_len), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .req_read_addr(b_req_addr), .req_read_len(b_req_len),
    .req_read_addr_valid(b_req_valid), .req_read_addr_ready(b_req_ready),
    .resp_read_data(b_resp_data), .resp_read_data_valid(b_resp_valid), .resp_read_data_ready(b_resp_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .busy(b_busy), .done(b_done)
  );

  logic [63:0] req_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] got_q[$];
  logic [63:0] b_req_q[$];
  int          b_pend = 0, b_done_cnt = 0;
  int          done_cnt = 0, resp_fires = 0, resp_limit = 1 << 30;
  bit          stall_resp = 0, stall_out = 0, out_hold = 0, busy_seen = 0;
  bit          hold_v = 0;
  logic [63:0] hold_req = '0;

  // Drivers change inputs just after the rising edge
  always @(posedge clk) begin
    #1;
    out_ready = !out_hold && (!stall_out || $urandom_range(0, 1) == 1);
    req_ready = !stall_resp || $urandom_range(0, 1) == 1;
    if (pend_q.size() > 0 && resp_fires < resp_limit && (!stall_resp || $urandom_range(0, 2) != 0)) begin
      resp_valid = 1'b1;
      resp_data  = data_of(pend_q[0]);
    end else begin
      resp_valid = 1'b0;
      resp_data  = '0;
    end
    b_resp_valid = (b_pend > 0);
  end

  // Monitors sample on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("req_stable_valid", req_valid, 1);
        chk("req_stable_addr_len", {req_addr, req_len}, hold_req);
      end
      hold_v   = req_valid && !req_ready;
      hold_req = {req_addr, req_len};
      if (req_valid && req_ready) begin
        req_q.push_back({req_addr, req_len});
        for (int unsigned i = 0; i < req_len; i++) pend_q.push_back(req_addr + i);
      end
      if (resp_valid && resp_ready) begin
        if (pend_q.size() > 0) void'(pend_q.pop_front());
        resp_fires++;
      end
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (done) done_cnt++;
      if (busy) busy_seen = 1;
      if (b_req_valid && b_req_ready) begin
        b_req_q.push_back({b_req_addr, b_req_len});
        b_pend += int'(b_req_len);
      end
      if (b_resp_valid && b_resp_ready) b_pend--;
      if (b_done) b_done_cnt++;
    end
  end

  task automatic send_a(input logic [31:0] addr, input logic [31:0] len);
    @(posedge clk); #1;
    cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_a(input int done_target, input int words);
    int n = 0;
    while ((done_cnt < done_target || got_q.size() < words) && n < 3000) begin
      @(posedge clk); n++;
    end
    chk("timeout", n < 3000, 1);
  endtask

  // Reference: split into min(remaining, 8) bursts; words in ascending address order
  task automatic check_run(input string nm, input logic [31:0] addr, input logic [31:0] len);
    logic [63:0] exp_q[$];
    logic [31:0] a = addr, r = len, b;
    while (r > 0) begin
      b = (r < 8) ? r : 8;
      exp_q.push_back({a, b});
      a += b; r -= b;
    end
    chk({nm, "_req_count"}, req_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < req_q.size(); i++)
      chk({nm, "_req"}, req_q[i], exp_q[i]);
    chk({nm, "_word_count"}, got_q.size(), len);
    for (int i = 0; i < got_q.size() && i < int'(len); i++)
      chk({nm, "_word"}, got_q[i], data_of(addr + 32'(i)));
  endtask

  task automatic clear_obs();
    req_q.delete(); got_q.delete(); busy_seen = 0;
  endtask

  task automatic run_a(input string nm, input logic [31:0] addr, input logic [31:0] len);
    int d0;
    clear_obs();
    d0 = done_cnt;
    send_a(addr, len);
    wait_a(d0 + 1, int'(len));
    repeat (4) @(posedge clk);
    check_run(nm, addr, len);
    chk({nm, "_single_done"}, done_cnt, d0 + 1);
  endtask

  initial begin
    int d0, n;
    logic [31:0] raddr;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_resp_ready", resp_ready, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // Three bursts: (0x100,8) (0x108,8) (0x110,4)
    run_a("len20", 32'h100, 32'd20);

    // Zero-length command
    clear_obs();
    d0 = done_cnt;
    send_a(32'h40, 32'd0);
    @(negedge clk);
    chk("len0_done_pulse", done, 1);
    chk("len0_busy", busy, 0);
    @(negedge clk);
    chk("len0_done_clear", done, 0);
    repeat (3) @(posedge clk);
    chk("len0_no_req", req_q.size(), 0);
    chk("len0_busy_never", busy_seen, 0);
    chk("len0_done_count", done_cnt, d0 + 1);

    // Credit stall with consumer blocked
    clear_obs();
    d0 = done_cnt;
    out_hold = 1;
    send_a(32'h2000, 32'd24);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("credit_req_count", req_q.size(), 2);
    chk("credit_req_valid_low", req_valid, 0);
    chk("credit_out_valid", out_valid, 1);
    chk("credit_busy", busy, 1);
    out_hold = 0;
    wait_a(d0 + 1, 24);
    repeat (4) @(posedge clk);
    check_run("credit", 32'h2000, 32'd24);

    // Random stalls on both sides
    stall_resp = 1; stall_out = 1;
    raddr = $urandom & 32'h0FFF_FFF0;
    run_a("stall37", raddr, 32'd37);
    if (req_q.size() == 5) chk("stall37_last_len", req_q[4][31:0], 5);
    stall_resp = 0; stall_out = 0;

    // Asynchronous reset mid-RESP with 3 words buffered
    clear_obs();
    out_hold = 1; resp_fires = 0; resp_limit = 3;
    send_a(32'h300, 32'd8);
    n = 0;
    while (resp_fires < 3 && n < 200) begin @(posedge clk); n++; end
    chk("mid_resp_timeout", n < 200, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_out_valid", out_valid, 1);
    chk("mid_busy", busy, 1);
    chk("mid_resp_ready", resp_ready, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_req_valid", req_valid, 0);
    chk("arst_resp_ready", resp_ready, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    pend_q.delete(); resp_limit = 1 << 30; out_hold = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_out_valid", out_valid, 0);
    run_a("post_rst", 32'h500, 32'd4);

    // Address wrap with 4-beat bursts
    @(posedge clk); #1;
    b_cmd_addr = 32'hFFFF_FFFC; b_cmd_len = 32'd8; b_cmd_valid = 1'b1;
    @(posedge clk); #1;
    b_cmd_valid = 1'b0;
    n = 0;
    while (b_done_cnt < 1 && n < 500) begin @(posedge clk); n++; end
    chk("wrap_timeout", n < 500, 1);
    @(negedge clk);
    chk("wrap_req_count", b_req_q.size(), 2);
    if (b_req_q.size() >= 2) begin
      chk("wrap_req0", b_req_q[0], {32'hFFFF_FFFC, 32'd4});
      chk("wrap_req1", b_req_q[1], {32'h0000_0000, 32'd4});
    end
    chk("wrap_idle", b_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
